updn_counter: RTL
=================

# updn_counter

Parametrised synchronous up/down counter, the next generation of the team's fixed 2-bit up counter. It adds configurable width and modulus, direction control, count enable, parallel load, and a wrap-or-saturate mode. It also adds a cascade-ready terminal-count output and a registered wrap pulse. It serves as the general-purpose event/timer counter for datapath and control blocks.

## Interface
- WIDTH, 4: counter width in bits, 1..32.
- MAX, 2**WIDTH-1: terminal value; count range is 0..MAX, with MAX ≤ 2**WIDTH-1.
- RST_VAL, 0: value loaded on reset; must be ≤ MAX.

Ports:
- clk  input  1  rising-edge clock; only clock in the block.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value for load.
- sat  input  1  1 = saturate at range ends, 0 = wrap.
- count_out  output  WIDTH  current count, registered.
- tc  output  1  terminal count, combinational.
- wrap  output  1  one-cycle registered pulse after a wrap.
- wrap_clr  input  1  clears sticky flag; present only with UPDN_COUNTER_STICKY_EN.
- wrap_sticky  output  1  sticky wrap flag; present only with UPDN_COUNTER_STICKY_EN.

## Operation
- Reset (reset = 0): count_out = RST_VAL, wrap = 0, wrap_sticky = 0. Applies immediately, independent of clk.
- Per rising edge, the first matching row applies:
  - load = 1: count_out ← min(load_val, MAX); wrap ← 0. load overrides en, up and sat.
  - en = 0: hold; wrap ← 0.
  - en = 1, up = 1, count < MAX: count + 1.
  - en = 1, up = 1, count = MAX: if sat = 0, count ← 0 and wrap ← 1; if sat = 1, hold at MAX and wrap ← 0.
  - en = 1, up = 0, count > 0: count − 1.
  - en = 1, up = 0, count = 0: if sat = 0, count ← MAX and wrap ← 1; if sat = 1, hold at 0.
- Count outside the range is unreachable: load clamps to MAX, and all arithmetic is modulo MAX+1, not 2**WIDTH.
- tc = en & ((up & count_out == MAX) | (~up & count_out == 0)).
  - tc is independent of sat and load.
  - Cascading: tc of a lower stage drives en of the next stage; all stages share up.
- Direction or sat may change on any cycle. The new value takes effect on that edge, with no pipeline delay.

## Timing
- Count latency: one clk edge from en/load sampled high to count_out updated.
- wrap is asserted for exactly the cycle following the wrapping edge. Consecutive wraps (e.g., MAX = 0 with en held) keep wrap high continuously.
- tc is combinational from en, up and count_out, so it is valid in the same cycle.
- Reset assertion mid-count forces RST_VAL asynchronously and discards any pending load.
- Reset deassertion: the first rising edge with reset = 1 is the first functional edge.
- With MAX = 0, count_out is always 0. Every enabled edge wraps unless sat = 1.

## Configuration
- Macro: UPDN_COUNTER_STICKY_EN.
- Defined:
  - Ports wrap_clr and wrap_sticky exist.
  - wrap_sticky is set on any edge where wrap is set, and cleared by wrap_clr = 1.
  - Simultaneous set and clear on the same edge: set wins.
  - Reset value of wrap_sticky is 0.
- Undefined: both ports and the flag register are absent; all other behaviour is identical.

## Test plan
- WIDTH = 4, MAX = 15, RST_VAL = 0: reset low, then en = 1, up = 1, sat = 0 for 17 edges -> count 1..15, 0, 1; wrap high only in the cycle after 15→0; tc high only while count = 15.
- MAX = 9, up = 0 from 0, sat = 0 -> count 9, 8, ...; wrap pulses once. Repeat with sat = 1 -> count holds 0, wrap never asserts, tc stays high.
- load = 1, load_val = 12, MAX = 9, en = 1 on the same edge -> count_out = 9 (clamped, load priority); the next up edge gives 0 with wrap = 1.
- Assert reset mid-count at count = 6, away from clk edges -> count_out = RST_VAL immediately and wrap = 0. The first edge after release counts from RST_VAL.
- Two 4-bit instances cascaded via tc→en, up = 1 -> high stage increments exactly once per 16 low-stage counts; combined value runs 0..255 and then wraps.
- With UPDN_COUNTER_STICKY_EN: force a wrap -> wrap_sticky = 1 and stays high. wrap_clr coincident with a new wrap -> stays 1. wrap_clr alone -> 0.

Source files
------------

// File: rtl/updn_counter.sv
// ---------------------------------------------------------------------------
// updn_counter
//
// Parametrised synchronous up/down counter. It supports count enable,
// direction control, parallel load, wrap-or-saturate mode, a combinational
// terminal-count output for cascading, and a registered wrap pulse.
//
// Parameters:
//   WIDTH    counter width in bits (1..32)
//   MAX      terminal value; the count range is 0..MAX (MAX <= 2**WIDTH-1)
//   RST_VAL  value taken on reset (must be <= MAX)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   en           count enable
//   up           direction: 1 = increment, 0 = decrement
//   load         synchronous parallel load (overrides en/up/sat)
//   load_val     value to load; clamped to MAX
//   sat          1 = saturate at the range ends, 0 = wrap
//   count_out    current count (registered)
//   tc           terminal count (combinational from en, up, count_out)
//   wrap         one-cycle registered pulse after a wrapping edge
//   wrap_clr     clears the sticky wrap flag   (UPDN_COUNTER_STICKY_EN only)
//   wrap_sticky  sticky wrap flag              (UPDN_COUNTER_STICKY_EN only)
//
// Optional feature macro: UPDN_COUNTER_STICKY_EN adds the sticky wrap flag.
// ---------------------------------------------------------------------------
module updn_counter #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat,
`ifdef UPDN_COUNTER_STICKY_EN
  input  logic             wrap_clr,
  output logic             wrap_sticky,
`endif
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;

  // Loaded values above MAX would leave the legal range, so they are clamped.
  function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] v);
    if (v > MAX) begin
      return MAX;
    end else begin
      return v;
    end
  endfunction

  // Next-count and wrap-pulse logic; the first matching condition wins.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = clamp_to_max(load_val);
    end else if (!en) begin
      count_d = count_q;
    end else if (up) begin
      if (count_q == MAX) begin
        // Arithmetic is modulo MAX+1, so wrapping up lands on zero.
        if (sat) begin
          count_d = count_q;
        end else begin
          count_d = ZERO;
          wrap_d  = 1'b1;
        end
      end else begin
        count_d = count_q + ONE;
      end
    end else begin
      if (count_q == ZERO) begin
        if (sat) begin
          count_d = count_q;
        end else begin
          count_d = MAX;
          wrap_d  = 1'b1;
        end
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RST_VAL;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef UPDN_COUNTER_STICKY_EN
  logic wrap_sticky_q;
  logic wrap_sticky_d;

  // Sticky flag: a new wrap takes precedence over a simultaneous clear.
  always_comb begin
    wrap_sticky_d = wrap_sticky_q;
    if (wrap_d) begin
      wrap_sticky_d = 1'b1;
    end else if (wrap_clr) begin
      wrap_sticky_d = 1'b0;
    end else begin
      wrap_sticky_d = wrap_sticky_q;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_sticky_q <= 1'b0;
    end else begin
      wrap_sticky_q <= wrap_sticky_d;
    end
  end

  assign wrap_sticky = wrap_sticky_q;
`endif

  // Terminal count is combinational so a cascaded stage sees it in the same
  // cycle and advances on the very edge where this stage wraps.
  assign tc        = en & ((up & (count_q == MAX)) | (~up & (count_q == ZERO)));
  assign count_out = count_q;
  assign wrap      = wrap_q;

endmodule
